serial_subtractor_nbit: RTL and testbench
=========================================

Name: serial_subtractor_nbit

Overview:
Bit-serial N-bit subtractor, the inverse-direction companion to the team's 1-bit adder cell. Computes diff = a - b - borrow_in, one bit per clock, LSB-first, using a single full-subtract cell and a registered borrow. A start/busy/done handshake sits in front of it. Used as a low-area datapath element wherever ripple subtraction latency is acceptable.

Parameters:
NUM_BITS, 8, operand and result width (legal range 2 to 32)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a  input  NUM_BITS  minuend; captured on the accepting edge
b  input  NUM_BITS  subtrahend; captured on the accepting edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result valid
diff  output  NUM_BITS  registered difference
borrow_out  output  1  unsigned borrow (a < b + borrow_in)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst=1): state IDLE. busy=0, done=0, diff=0, borrow_out=0, overflow=0. Shift registers, bit counter and borrow flop cleared. Reset mid-SHIFT aborts the operation; no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an edge with start=1:
  - load a and b into shift registers
  - borrow flop = 0 (or borrow_in, see Optional Feature)
  - counter = 0
- SHIFT, each edge:
  - d = a0 ^ b0 ^ bor
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - d shifts into the result register from the MSB side; operand registers shift right
  - counter increments
  - the edge processing counter == NUM_BITS-1 moves to DONE
- Entering DONE, in the same edge:
  - diff <= assembled result
  - borrow_out <= final bor_next
  - overflow <= (a_msb != b_msb) & (d_msb != a_msb), using the MSBs of the captured operands
- DONE lasts one cycle with done=1 and busy=0.
  - start=1 in DONE: back-to-back accept, go to SHIFT and load the new operands.
  - Otherwise go to IDLE.
- Latency: done is high during the cycle that begins NUM_BITS rising edges after the accepting edge. Throughput is one result per NUM_BITS+1 cycles, back-to-back.
- start while busy=1 is ignored. Operands may change freely after the accepting edge.
- diff, borrow_out and overflow hold their values until the next DONE entry or reset. They never show partial results.
- busy = (state == SHIFT). done = (state == DONE). Both are decoded from registered state only.
- Simulation-only assertions: a, b and start must not be X/Z on an accepting edge. Report violations with $error.

Optional Feature:
Macro SERIAL_SUB_BORROW_IN_EN.
- Defined:
  - adds input port borrow_in (1 bit), captured on the accepting edge as the initial borrow
  - result = a - b - borrow_in
  - overflow = signed overflow of that full expression
- Undefined:
  - no borrow_in port
  - initial borrow is constant 0

Test Plan:
Stimulus and required responses below use NUM_BITS=8.
1. a=0x05, b=0x03, start 1 cycle -> exactly 8 edges later done=1 for 1 cycle; diff=0x02, borrow_out=0, overflow=0.
2. a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
3. a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1. a=0x00, b=0x00 -> diff=0x00, all flags 0.
4. Start 0x10-0x01; pulse start with 0x20-0x01 at SHIFT edge 3 -> ignored. Single done, diff=0x0F. Hold start=1 into DONE with 0x20-0x01 -> back-to-back result 0x1F, 9 cycles after the first done.
5. Assert rst asynchronously mid-SHIFT (edge 4) -> all outputs 0 immediately, no done. A fresh start of 0x09-0x04 after reset -> diff=0x05.
6. With SERIAL_SUB_BORROW_IN_EN: a=0x05, b=0x03, borrow_in=1 -> diff=0x01, borrow_out=0. a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.

Source files
------------

// File: rtl/serial_subtractor_nbit.sv
// serial_subtractor_nbit
//
// Bit-serial N-bit subtractor: diff = a - b (- borrow_in), LSB-first, one bit per clock,
// using a single full-subtract cell and a registered borrow. A start/busy/done handshake
// fronts the datapath. One result every NUM_BITS+1 cycles when started back-to-back.
//
// Parameters:
//   NUM_BITS    operand / result width, 2..32 (default 8)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       request; sampled only in IDLE or DONE
//   a, b        minuend / subtrahend, captured on the accepting edge
//   borrow_in   initial borrow (only with SERIAL_SUB_BORROW_IN_EN)
//   busy        high while shifting
//   done        one-cycle pulse, result outputs valid
//   diff        registered difference
//   borrow_out  unsigned borrow (a < b + borrow_in)
//   overflow    two's-complement signed overflow
//
// Build option:
//   SERIAL_SUB_BORROW_IN_EN  when defined, adds the borrow_in port used as the initial
//                            borrow; otherwise the initial borrow is constant 0.

module serial_subtractor_nbit #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic                borrow_in,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BITS - 1);

  if (NUM_BITS < 2 || NUM_BITS > 32) begin : gen_bad_width
    $error("serial_subtractor_nbit: NUM_BITS must be in 2..32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e state_q, state_d;

  // The minuend register doubles as the result register: each shift drops the consumed
  // operand bit off the LSB end and inserts the new difference bit at the MSB end, so after
  // NUM_BITS shifts it holds the complete difference.
  logic [NUM_BITS-1:0] a_sh_q, a_sh_d;
  logic [NUM_BITS-1:0] b_sh_q, b_sh_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                bor_q, bor_d;
  logic                a_msb_q, a_msb_d;
  logic                b_msb_q, b_msb_d;

  logic [NUM_BITS-1:0] diff_q, diff_d;
  logic                borrow_out_q, borrow_out_d;
  logic                overflow_q, overflow_d;

  logic bor_init;
  logic bit_d;
  logic bor_next;
  logic last_bit;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bor_init = borrow_in;
`else
  assign bor_init = 1'b0;
`endif

  // Full-subtract cell on the current LSBs.
  assign bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
  assign bor_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
  assign last_bit = (cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    bor_d        = bor_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StShift;
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[NUM_BITS-1];
          b_msb_d = b[NUM_BITS-1];
          bor_d   = bor_init;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StShift: begin
        a_sh_d = {bit_d, a_sh_q[NUM_BITS-1:1]};
        b_sh_d = {1'b0, b_sh_q[NUM_BITS-1:1]};
        bor_d  = bor_next;
        cnt_d  = cnt_q + CntW'(1);
        if (last_bit) begin
          state_d      = StDone;
          cnt_d        = '0;
          diff_d       = {bit_d, a_sh_q[NUM_BITS-1:1]};
          borrow_out_d = bor_next;
          // Signed overflow: operand signs differ and the result sign differs from a's.
          overflow_d   = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      bor_q        <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      bor_q        <= bor_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

`ifndef SYNTHESIS
  // Inputs that matter on an accepting edge must be known.
  always @(posedge clk) begin
    if (!rst && (state_q == StIdle || state_q == StDone)) begin
      assert (!$isunknown(start))
        else $error("serial_subtractor_nbit: start is X/Z while idle or done");
      if (start === 1'b1) begin
        assert (!$isunknown({a, b}))
          else $error("serial_subtractor_nbit: a/b is X/Z on an accepting edge");
`ifdef SERIAL_SUB_BORROW_IN_EN
        assert (!$isunknown(borrow_in))
          else $error("serial_subtractor_nbit: borrow_in is X/Z on an accepting edge");
`endif
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit (NUM_BITS=8): directed cases plus random
// operands compared against an arithmetic reference model.

module tb_serial_subtractor_nbit;

  localparam int unsigned N       = 8;
  localparam int          MaxWait = 3 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_nbit #(
    .NUM_BITS(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .borrow_in  (bin),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  // Reference: {overflow, borrow, diff} of a - b - c from plain integer arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                                         input logic op_c);
    longint ua, ub, uc, full, half, sa, sb, s;
    logic [N-1:0] d;
    logic bo, ov;
    ua   = longint'(op_a);
    ub   = longint'(op_b);
    uc   = longint'(op_c);
    full = ua - ub - uc;
    half = longint'(1) << (N - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    s    = sa - sb - uc;
    d    = full[N-1:0];
    bo   = (full < 0);
    ov   = (s < -half) || (s > half - 1);
    return {ov, bo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [N-1:0] e_diff, input logic e_bo,
                           input logic e_ov);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(e_diff));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e_bo));
    check({tag, "_ovf"}, 32'(overflow), 32'(e_ov));
  endtask

  // Drive a request just after an edge, let the next edge accept it, then scramble inputs.
  task automatic start_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                          input logic op_c);
    a     = op_a;
    b     = op_b;
    bin   = op_c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Count edges until done is seen (sampled 1 time unit after each edge), bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (done !== 1'b1 && edges < MaxWait);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                          input logic op_c, input logic [N-1:0] e_diff, input logic e_bo,
                          input logic e_ov);
    int e;
    start_op(op_a, op_b, op_c);
    wait_done(e);
    check({tag, "_latency"}, 32'(e), 32'(N));
    check_res(tag, e_diff, e_bo, e_ov);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int e;
    int done_cnt;
    logic [N-1:0] ra, rb;
    logic rc;
    logic [N+1:0] m;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic, borrow, signed overflow, zero cases.
    directed("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    directed("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    directed("t2b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    directed("t3a", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    directed("t3b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // start during SHIFT is ignored; start held into DONE is accepted back-to-back.
    start_op(8'h10, 8'h01, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a     = 8'h20;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(e);
    check("t4_first_latency", 32'(e), 32'(N - 3));
    check_res("t4_first", 8'h0F, 1'b0, 1'b0);
    a     = 8'h20;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_b2b_nodone", 32'(done), 32'd0);
    check("t4_b2b_busy", 32'(busy), 32'd1);
    wait_done(e);
    check("t4_b2b_gap", 32'(e + 1), 32'(N + 1));
    check_res("t4_b2b", 8'h1F, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-SHIFT clears outputs at once and suppresses done.
    start_op(8'h55, 8'h22, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_borrow", 32'(borrow_out), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    done_cnt = 0;
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    directed("t5_fresh", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

`ifdef SERIAL_SUB_BORROW_IN_EN
    directed("t6a", 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0);
    directed("t6b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
`endif

    // Random operands, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
`ifdef SERIAL_SUB_BORROW_IN_EN
      rc = 1'($urandom_range(1, 0));
`else
      rc = 1'b0;
`endif
      start_op(ra, rb, rc);
      wait_done(e);
      check("rnd_latency", 32'(e), 32'(N));
      m = model(ra, rb, rc);
      check_res("rnd", m[N-1:0], m[N], m[N+1]);
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
        check("rnd_pulse", 32'(done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
